// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and default constants for the PWM duty-cycle
//                control path and the PWM generator that consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Duty register width and its limits, shared with the PWM generator
    localparam int DUTY_W    = 7;
    localparam int DUTY_MAX  = 127;
    localparam int DUTY_INIT = 63;

    // Default button timing at the nominal 12.5 kHz clock
    localparam int DEBOUNCE_CYCLES_DEF = 512;
    localparam int REPEAT_DELAY_DEF    = 6250;
    localparam int REPEAT_PERIOD_DEF   = 1250;

    // Per-button auto-repeat state; ST_FIRST is reserved and behaves as ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ctrl_if
//  Description : Button inputs and duty/strobe outputs of the duty controller.
//                master = stimulus side, slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_ctrl_if;
    import pwm_pkg::*;

    logic              btn_inc;
    logic              btn_dec;
    logic [DUTY_W-1:0] duty;
    logic              duty_changed;
    logic              inc_pulse;
    logic              dec_pulse;
    logic              at_max;
    logic              at_min;

    modport master (
        output btn_inc, btn_dec,
        input  duty, duty_changed, inc_pulse, dec_pulse, at_max, at_min
    );

    modport slave (
        input  btn_inc, btn_dec,
        output duty, duty_changed, inc_pulse, dec_pulse, at_max, at_min
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchronizer followed by a debounce counter. A new level
//                is accepted only after DEBOUNCE_CYCLES consecutive samples
//                that disagree with the current stable level.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_btn,
    output logic o_stable
);

    localparam int                c_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    // Synchronize the raw button and accept a level once it has held long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (r_s2 != r_stable) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ctrl
//  Description : Debounces the increment/decrement buttons, runs one
//                auto-repeat FSM per button and owns the saturating duty
//                register with its limit flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_MAX        = pwm_pkg::DUTY_MAX,
    parameter int DUTY_INIT       = pwm_pkg::DUTY_INIT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  wire            clk,
    input  wire            rst,
    pwm_duty_ctrl_if.slave bus
);

    localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_DELAY_LD  = c_TMR_W'(REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_LD = c_TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [DUTY_W-1:0]  c_DUTY_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0]  c_DUTY_INIT = DUTY_W'(DUTY_INIT);

    // Index 0 = increment button, index 1 = decrement button
    logic [1:0]        w_stable;
    logic [1:0]        w_step;
    logic              w_conflict;

    logic [DUTY_W-1:0] r_duty;
    logic              r_changed;
    logic              r_inc_pulse;
    logic              r_dec_pulse;
    logic              r_at_max;
    logic              r_at_min;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              w_changed_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (bus.btn_inc),
        .o_stable (w_stable[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (bus.btn_dec),
        .o_stable (w_stable[1])
    );

    // Both buttons held: neither may step, and both park in HOLD at full delay
    assign w_conflict = w_stable[0] & w_stable[1];

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_state_t         r_state;
        btn_state_t         w_state_nxt;
        logic [c_TMR_W-1:0] r_tmr;
        logic [c_TMR_W-1:0] w_tmr_nxt;
        logic               w_step_b;

        // State and repeat timer registers
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_tmr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_tmr   <= w_tmr_nxt;
            end
        end

        // Next state: release wins, then conflict, then normal repeat timing
        always_comb begin
            w_state_nxt = r_state;
            w_tmr_nxt   = r_tmr;
            if (!w_stable[i]) begin
                w_state_nxt = ST_IDLE;
                w_tmr_nxt   = c_DELAY_LD;
            end else if (w_conflict) begin
                w_state_nxt = ST_HOLD;
                w_tmr_nxt   = c_DELAY_LD;
            end else begin
                case (r_state)
                    ST_HOLD: begin
                        if (r_tmr == '0) begin
                            w_state_nxt = ST_REPEAT;
                            w_tmr_nxt   = c_PERIOD_LD;
                        end else begin
                            w_tmr_nxt = r_tmr - 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_tmr == '0) begin
                            w_tmr_nxt = c_PERIOD_LD;
                        end else begin
                            w_tmr_nxt = r_tmr - 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_HOLD;
                        w_tmr_nxt   = c_DELAY_LD;
                    end
                endcase
            end
        end

        // Step on a fresh press or when the hold/repeat timer expires
        always_comb begin
            w_step_b = 1'b0;
            if (w_stable[i] && !w_conflict) begin
                case (r_state)
                    ST_HOLD, ST_REPEAT: w_step_b = (r_tmr == '0);
                    default:            w_step_b = 1'b1;
                endcase
            end
        end

        assign w_step[i] = w_step_b;
    end

    // Saturating duty update; a step at the limit leaves duty untouched
    always_comb begin
        w_duty_nxt    = r_duty;
        w_changed_nxt = 1'b0;
        if (w_step[0] && (r_duty < c_DUTY_MAX)) begin
            w_duty_nxt    = r_duty + 1'b1;
            w_changed_nxt = 1'b1;
        end else if (w_step[1] && (r_duty != '0)) begin
            w_duty_nxt    = r_duty - 1'b1;
            w_changed_nxt = 1'b1;
        end
    end

    // Duty, strobes and limit flags registered together so they always agree
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty      <= c_DUTY_INIT;
            r_changed   <= 1'b0;
            r_inc_pulse <= 1'b0;
            r_dec_pulse <= 1'b0;
            r_at_max    <= (c_DUTY_INIT == c_DUTY_MAX);
            r_at_min    <= (c_DUTY_INIT == '0);
        end else begin
            r_duty      <= w_duty_nxt;
            r_changed   <= w_changed_nxt;
            r_inc_pulse <= w_step[0];
            r_dec_pulse <= w_step[1];
            r_at_max    <= (w_duty_nxt == c_DUTY_MAX);
            r_at_min    <= (w_duty_nxt == '0);
        end
    end

    assign bus.duty         = r_duty;
    assign bus.duty_changed = r_changed;
    assign bus.inc_pulse    = r_inc_pulse;
    assign bus.dec_pulse    = r_dec_pulse;
    assign bus.at_max       = r_at_max;
    assign bus.at_min       = r_at_min;

endmodule
`default_nettype wire
